// File: rtl/enc_pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
// Package  : enc_pulse_gen_pkg
// Brief    : Shared state encoding and default timing for the encoder blocks.
// Revision : 1.0 - initial release
// ============================================================================
package enc_pulse_gen_pkg;

    localparam int unsigned c_WIN_LEN_DEF = 1024;
    localparam int unsigned c_PULSE_W_DEF = 4;
    localparam int unsigned c_RATE_W      = 7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } enc_state_t;

endpackage
`default_nettype wire

// File: rtl/enc_pulse_gen_if.sv
`default_nettype none
// ============================================================================
// Interface : enc_pulse_gen_if
// Brief     : Rate handshake and pulse-train outputs of the encoder emulator.
// Revision  : 1.0 - initial release
// ============================================================================
interface enc_pulse_gen_if;
    import enc_pulse_gen_pkg::*;

    logic                en;
    logic [c_RATE_W-1:0] rate;
    logic                rate_valid;
    logic                rate_ready;
    logic                pulse;
    logic                new_clk;
    logic [c_RATE_W-1:0] sent;
    logic                active;

    modport master (
        output en, rate, rate_valid,
        input  rate_ready, pulse, new_clk, sent, active
    );

    modport slave (
        input  en, rate, rate_valid,
        output rate_ready, pulse, new_clk, sent, active
    );

endinterface
`default_nettype wire

// File: rtl/enc_pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module   : enc_pulse_stretch
// Brief    : Turns a one-cycle start strobe into a PULSE_W-cycle high level.
// Revision : 1.0 - initial release
// ============================================================================
module enc_pulse_stretch
    import enc_pulse_gen_pkg::*;
#(
    parameter int unsigned PULSE_W = c_PULSE_W_DEF
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_start,
    output logic      o_pulse
);

    localparam int unsigned          c_CNT_W = $clog2(PULSE_W + 1);
    localparam logic [c_CNT_W-1:0]   c_LOAD  = c_CNT_W'(PULSE_W);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= c_LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    assign o_pulse = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/enc_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : enc_pulse_gen
// Brief    : Emulated encoder; spreads 'rate' pulses evenly over each window.
// Revision : 1.0 - initial release
// ============================================================================
module enc_pulse_gen
    import enc_pulse_gen_pkg::*;
#(
    parameter int unsigned WIN_LEN = c_WIN_LEN_DEF,
    parameter int unsigned PULSE_W = c_PULSE_W_DEF
) (
    input  wire logic      clk,
    input  wire logic      reset,
    enc_pulse_gen_if.slave bus
);

    localparam int unsigned          c_K_W    = $clog2(WIN_LEN);
    localparam int unsigned          c_ACC_W  = $clog2(WIN_LEN + 128);
    localparam logic [c_K_W-1:0]     c_K_LAST = c_K_W'(WIN_LEN - 1);
    localparam logic [c_ACC_W-1:0]   c_WIN    = c_ACC_W'(WIN_LEN);

    enc_state_t          r_state;
    enc_state_t          w_state_next;
    logic [c_K_W-1:0]    r_k;
    logic [c_ACC_W-1:0]  r_acc;
    logic [c_ACC_W-1:0]  w_acc_sum;
    logic [c_ACC_W-1:0]  w_acc_next;
    logic [c_RATE_W-1:0] r_act_rate;
    logic [c_RATE_W-1:0] r_pend_val;
    logic [c_RATE_W-1:0] w_rate_eff;
    logic [c_RATE_W-1:0] r_cnt;
    logic [c_RATE_W-1:0] w_cnt_next;
    logic [c_RATE_W-1:0] r_sent;
    logic                r_pend;
    logic                w_run;
    logic                w_first;
    logic                w_last;
    logic                w_load;
    logic                w_accept;
    logic                w_start;
    logic                w_pulse;

    always_comb begin
        w_state_next = r_state;
        w_run        = (r_state == ST_RUN);
        w_first      = w_run && (r_k == '0);
        w_last       = w_run && (r_k == c_K_LAST);
        w_load       = w_first && r_pend;
        w_accept     = bus.rate_valid && !r_pend;
        // A rate promoted on k=0 already drives this window's first add.
        w_rate_eff   = w_load ? r_pend_val : r_act_rate;
        w_acc_sum    = (w_first ? {c_ACC_W{1'b0}} : r_acc)
                     + {{(c_ACC_W - c_RATE_W){1'b0}}, w_rate_eff};
        w_start      = w_run && (w_acc_sum >= c_WIN);
        w_acc_next   = w_start ? (w_acc_sum - c_WIN) : w_acc_sum;
        w_cnt_next   = r_cnt + {{(c_RATE_W - 1){1'b0}}, w_start};
        case (r_state)
            ST_IDLE: if (bus.en)            w_state_next = ST_RUN;
            ST_RUN:  if (w_last && !bus.en) w_state_next = ST_IDLE;
            default:                        w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_k        <= '0;
            r_acc      <= '0;
            r_act_rate <= '0;
            r_pend_val <= '0;
            r_pend     <= 1'b0;
            r_cnt      <= '0;
            r_sent     <= '0;
        end else begin
            if (w_load) begin
                r_act_rate <= r_pend_val;
                r_pend     <= 1'b0;
            end else if (w_accept) begin
                r_pend_val <= bus.rate;
                r_pend     <= 1'b1;
            end
            if (w_run) begin
                r_k   <= w_last ? '0 : r_k + c_K_W'(1);
                r_acc <= w_acc_next;
            end else begin
                r_k   <= '0;
                r_acc <= '0;
            end
            if (w_last) begin
                r_sent <= w_cnt_next;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= w_cnt_next;
            end
        end
    end

    enc_pulse_stretch #(
        .PULSE_W (PULSE_W)
    ) u_stretch (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .o_pulse (w_pulse)
    );

    assign bus.rate_ready = !r_pend;
    assign bus.pulse      = w_pulse;
    assign bus.new_clk    = w_last;
    assign bus.sent       = r_sent;
    assign bus.active     = w_run;

endmodule
`default_nettype wire

// File: tb/tb_enc_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_enc_pulse_gen
// Brief    : Self-checking bench for enc_pulse_gen against a window-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enc_pulse_gen;
    import enc_pulse_gen_pkg::*;

    localparam int W  = 1024;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    enc_pulse_gen_if bus();

    enc_pulse_gen #(.WIN_LEN(W), .PULSE_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    int     m_run, m_k, m_act, m_pend, m_pval, m_cnt, m_sent;
    longint m_cyc, m_last;

    // Pulse j of a window starts where floor((k+1)*r/W) first reaches j.
    function automatic bit starts_at(int k, int r);
        return (r > 0) && ((((k + 1) * r) / W) != ((k * r) / W));
    endfunction

    function automatic logic [10:0] exp_v();
        logic p;
        p = ((m_cyc - m_last) >= 1) && ((m_cyc - m_last) <= PW);
        return {m_run != 0, m_pend == 0, (m_run != 0) && (m_k == W - 1), p, 7'(m_sent)};
    endfunction

    function automatic logic [10:0] obs();
        return {bus.active, bus.rate_ready, bus.new_clk, bus.pulse, bus.sent};
    endfunction

    task automatic model_step();
        int r_eff;
        bit st, nc, ld;
        if (reset === 1'b0) begin
            m_run = 0; m_k = 0; m_act = 0; m_pend = 0; m_pval = 0;
            m_cnt = 0; m_sent = 0; m_last = -1000;
        end else begin
            ld    = (m_run != 0) && (m_k == 0) && (m_pend != 0);
            r_eff = ld ? m_pval : m_act;
            st    = (m_run != 0) && starts_at(m_k, r_eff);
            nc    = (m_run != 0) && (m_k == W - 1);
            if (ld) begin
                m_act = m_pval; m_pend = 0;
            end else if (bus.rate_valid === 1'b1 && m_pend == 0) begin
                m_pend = 1; m_pval = int'(bus.rate);
            end
            if (st) m_last = m_cyc;
            if (nc) begin m_sent = m_cnt + int'(st); m_cnt = 0; end
            else m_cnt = m_cnt + int'(st);
            if (m_run == 0) begin
                if (bus.en === 1'b1) m_run = 1;
                m_k = 0;
            end else begin
                if (nc && bus.en !== 1'b1) m_run = 0;
                m_k = nc ? 0 : m_k + 1;
            end
        end
        m_cyc++;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic offer(input logic [6:0] v);
        bit ok;
        ok = 0;
        for (int i = 0; i < 2 * W && !ok; i++) begin
            if (bus.rate_ready === 1'b1) ok = 1;
            else tick();
        end
        total++;
        if (!ok) begin bad++; $display("FAIL offer_wait got=ready_low want=ready_high"); end
        bus.rate = v; bus.rate_valid = 1'b1;
        tick();
        bus.rate_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.en = 1'b0; bus.rate_valid = 1'b0; bus.rate = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (obs() !== exp_v()) begin bad++; $display("FAIL reset cyc=%0d got=%h want=%h", m_cyc, obs(), exp_v()); end
        end
        total++; if (obs() !== 11'b01000000000) begin bad++; $display("FAIL reset_values got=%b want=%b", obs(), 11'b01000000000); end
        reset = 1'b1;
        tick();
        total++; if (obs() !== exp_v()) begin bad++; $display("FAIL reset_release cyc=%0d got=%h want=%h", m_cyc, obs(), exp_v()); end
    endtask

    task automatic test_rate_zero();
        int nclk;
        nclk = 0;
        bus.en = 1'b1;
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            total++; if (obs() !== exp_v()) begin bad++; $display("FAIL rate0 cyc=%0d got=%h want=%h", m_cyc, obs(), exp_v()); end
            if (bus.new_clk === 1'b1) nclk++;
        end
        total++; if (nclk != 2) begin bad++; $display("FAIL rate0_newclk got=%0d want=2", nclk); end
        total++; if (bus.sent !== 7'd0) begin bad++; $display("FAIL rate0_sent got=%0d want=0", bus.sent); end
    endtask

    task automatic test_rate4();
        logic prev;
        offer(7'd4);
        prev = bus.pulse;
        for (int i = 0; i < 3 * W; i++) begin
            tick();
            total++; if (obs() !== exp_v()) begin bad++; $display("FAIL rate4 cyc=%0d got=%h want=%h", m_cyc, obs(), exp_v()); end
            if (bus.pulse === 1'b1 && prev !== 1'b1) begin
                total++; if ((m_k % 256) != 0) begin bad++; $display("FAIL rate4_rise_k got=%0d want=multiple_of_256", m_k); end
            end
            prev = bus.pulse;
        end
        total++; if (bus.sent !== 7'd4) begin bad++; $display("FAIL rate4_sent got=%0d want=4", bus.sent); end
    endtask

    task automatic test_rate_max();
        logic prev;
        int win, rises;
        win = 0; rises = 0;
        offer(7'd127);
        prev = bus.pulse;
        for (int i = 0; i < 4 * W; i++) begin
            tick();
            total++; if (obs() !== exp_v()) begin bad++; $display("FAIL rate127 cyc=%0d got=%h want=%h", m_cyc, obs(), exp_v()); end
            if (bus.pulse === 1'b1 && prev !== 1'b1 && win == 2) rises++;
            if (bus.new_clk === 1'b1) win++;
            prev = bus.pulse;
        end
        total++; if (rises != 127) begin bad++; $display("FAIL rate127_rises got=%0d want=127", rises); end
        total++; if (bus.sent !== 7'd127) begin bad++; $display("FAIL rate127_sent got=%0d want=127", bus.sent); end
    endtask

    task automatic test_pending();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2 * W && !ok; i++) begin
            tick();
            total++; if (obs() !== exp_v()) begin bad++; $display("FAIL pend_pre cyc=%0d got=%h want=%h", m_cyc, obs(), exp_v()); end
            if (m_run != 0 && m_k == 5 && m_pend == 0) ok = 1;
        end
        total++; if (!ok) begin bad++; $display("FAIL pend_align got=timeout want=k5"); end
        bus.rate = 7'd10; bus.rate_valid = 1'b1;
        tick();
        total++; if (bus.rate_ready !== 1'b0) begin bad++; $display("FAIL pend_ready_low got=%b want=0", bus.rate_ready); end
        bus.rate = 7'd20;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (obs() !== exp_v()) begin bad++; $display("FAIL pend_ignore cyc=%0d got=%h want=%h", m_cyc, obs(), exp_v()); end
            total++; if (bus.rate_ready !== 1'b0) begin bad++; $display("FAIL pend_ready_hold got=%b want=0", bus.rate_ready); end
        end
        bus.rate_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < W + 10 && !ok; i++) begin
            tick();
            total++; if (obs() !== exp_v()) begin bad++; $display("FAIL pend_wait cyc=%0d got=%h want=%h", m_cyc, obs(), exp_v()); end
            if (m_k == 1) ok = 1;
        end
        total++; if (!ok || bus.rate_ready !== 1'b1) begin bad++; $display("FAIL pend_ready_back got=%b want=1", bus.rate_ready); end
        ok = 0;
        for (int i = 0; i < W + 10 && !ok; i++) begin
            tick();
            total++; if (obs() !== exp_v()) begin bad++; $display("FAIL pend_run cyc=%0d got=%h want=%h", m_cyc, obs(), exp_v()); end
            if (bus.new_clk === 1'b1) ok = 1;
        end
        tick();
        total++; if (bus.sent !== 7'd10) begin bad++; $display("FAIL pend_sent got=%0d want=10", bus.sent); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4 * W; i++) begin
            if (bus.rate_valid === 1'b1) bus.rate_valid = 1'b0;
            else if (bus.rate_ready === 1'b1 && $urandom_range(0, 299) == 0) begin
                bus.rate = 7'($urandom_range(0, 127));
                bus.rate_valid = 1'b1;
            end
            if ($urandom_range(0, 1499) == 0) bus.en = ~bus.en;
            tick();
            total++; if (obs() !== exp_v()) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", m_cyc, obs(), exp_v()); end
        end
        bus.rate_valid = 1'b0;
        bus.en = 1'b1;
    endtask

    task automatic test_en_drop();
        bit ok;
        offer(7'd50);
        ok = 0;
        for (int i = 0; i < 3 * W && !ok; i++) begin
            tick();
            total++; if (obs() !== exp_v()) begin bad++; $display("FAIL endrop_pre cyc=%0d got=%h want=%h", m_cyc, obs(), exp_v()); end
            if (m_run != 0 && m_act == 50 && m_k == 300) ok = 1;
        end
        total++; if (!ok) begin bad++; $display("FAIL endrop_align got=timeout want=k300"); end
        bus.en = 1'b0;
        ok = 0;
        for (int i = 0; i < W && !ok; i++) begin
            tick();
            total++; if (obs() !== exp_v()) begin bad++; $display("FAIL endrop_run cyc=%0d got=%h want=%h", m_cyc, obs(), exp_v()); end
            if (bus.new_clk === 1'b1) ok = 1;
        end
        total++; if (!ok) begin bad++; $display("FAIL endrop_newclk got=timeout want=new_clk"); end
        tick();
        total++; if (bus.active !== 1'b0) begin bad++; $display("FAIL endrop_active got=%b want=0", bus.active); end
        for (int i = 0; i < 200; i++) begin
            tick();
            total++; if (obs() !== exp_v()) begin bad++; $display("FAIL endrop_idle cyc=%0d got=%h want=%h", m_cyc, obs(), exp_v()); end
            if (i >= 10) begin
                total++; if (bus.pulse !== 1'b0) begin bad++; $display("FAIL endrop_pulse got=%b want=0", bus.pulse); end
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        bit ok;
        bus.en = 1'b1;
        ok = 0;
        for (int i = 0; i < 2 * W && !ok; i++) begin
            tick();
            total++; if (obs() !== exp_v()) begin bad++; $display("FAIL rstmid_pre cyc=%0d got=%h want=%h", m_cyc, obs(), exp_v()); end
            if (bus.pulse === 1'b1) ok = 1;
        end
        total++; if (!ok) begin bad++; $display("FAIL rstmid_wait got=timeout want=pulse"); end
        reset = 1'b0;
        tick();
        total++; if (obs() !== 11'b01000000000) begin bad++; $display("FAIL rstmid_values got=%b want=%b", obs(), 11'b01000000000); end
        reset = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            total++; if (obs() !== exp_v()) begin bad++; $display("FAIL rstmid_after cyc=%0d got=%h want=%h", m_cyc, obs(), exp_v()); end
            total++; if (bus.pulse !== 1'b0) begin bad++; $display("FAIL rstmid_pulse got=%b want=0", bus.pulse); end
        end
    endtask

    initial begin
        m_cyc = 0; m_last = -1000;
        m_run = 0; m_k = 0; m_act = 0; m_pend = 0; m_pval = 0; m_cnt = 0; m_sent = 0;
        reset = 1'b0; bus.en = 1'b0; bus.rate = '0; bus.rate_valid = 1'b0;
        test_reset();
        test_rate_zero();
        test_rate4();
        test_rate_max();
        test_pending();
        test_random();
        test_en_drop();
        test_reset_mid_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
